// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: scan-code prefixes, key event payload, frame states.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } ps2_evt_t;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} ps2_state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of decoded key events; a push while full is accepted only alongside a pop.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  ps2_evt_t               push_evt_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output ps2_evt_t               head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    ps2_evt_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty, full, do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop_i && !empty;
        do_push  = push_i && (!full || do_pop);
        drop_o   = push_i && full && !do_pop;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_evt_i;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign valid_o = !empty;
    assign head_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_event_decoder.sv
// PS/2 keyboard receiver: synchronise and filter the line, frame bytes, fold E0/F0 prefixes
// into key events and buffer them in a FIFO.
module ps2_event_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter bit          ODD_PARITY  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_make,
    output logic                        evt_ext,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          flt_lvl_q, flt_lvl_d, fall, bit_in;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic          perr_q, perr_d, ferr_q, ferr_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          ovf_q, drop, push;
    ps2_evt_t      push_evt, head;

    // The filtered level only follows the synchronised clock after FILTER_LEN stable cycles.
    always_comb begin
        flt_lvl_d = flt_lvl_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != flt_lvl_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_lvl_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
        fall   = flt_lvl_q && !flt_lvl_d;
        bit_in = data_sync_q[1];
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        byte_vld_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        if (state_q != StIdle && !fall) begin
            tmo_d = tmo_q + TW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (fall && !bit_in) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    par_d   = bit_in;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    state_d = StIdle;
                    if (!bit_in) begin
                        ferr_d = 1'b1;
                    end else if ((^{shift_q, par_q}) != ODD_PARITY) begin
                        perr_d = 1'b1;
                    end else begin
                        byte_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = StIdle;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    // A good byte is still held in shift_q the cycle after the stop bit.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        push_evt = '{code: shift_q, make: ~brk_q, ext: ext_q};
        if (perr_d || ferr_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            flt_lvl_q   <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_vld_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            flt_lvl_q   <= flt_lvl_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_vld_q  <= byte_vld_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ovf_q       <= drop;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .push_evt_i (push_evt),
        .pop_i      (evt_ready),
        .valid_o    (evt_valid),
        .head_o     (head),
        .count_o    (evt_count),
        .drop_o     (drop)
    );

    assign evt_code   = head.code;
    assign evt_make   = head.make;
    assign evt_ext    = head.ext;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Directed bench: dut0 uses odd parity and a 4-deep FIFO, dut1 uses even parity.
module tb_ps2_event_decoder;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, evt_ready;

    logic       evt_valid0, evt_make0, evt_ext0, parity_err0, frame_err0, overflow0;
    logic [7:0] evt_code0;
    logic [2:0] evt_count0;
    logic       evt_valid1, evt_make1, evt_ext1, parity_err1, frame_err1, overflow1;
    logic [7:0] evt_code1;
    logic [3:0] evt_count1;

    int n_checks = 0;
    int n_fail   = 0;
    int perr0 = 0, ferr0 = 0, ovf0 = 0;

    always #5 clk = ~clk;

    ps2_event_decoder #(
        .FILTER_LEN  (2),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (100),
        .ODD_PARITY  (1'b1)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid0),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code0),
        .evt_make   (evt_make0),
        .evt_ext    (evt_ext0),
        .evt_count  (evt_count0),
        .parity_err (parity_err0),
        .frame_err  (frame_err0),
        .overflow   (overflow0)
    );

    ps2_event_decoder #(
        .FILTER_LEN  (2),
        .FIFO_DEPTH  (8),
        .TIMEOUT_CYC (100),
        .ODD_PARITY  (1'b0)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid1),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code1),
        .evt_make   (evt_make1),
        .evt_ext    (evt_ext1),
        .evt_count  (evt_count1),
        .parity_err (parity_err1),
        .frame_err  (frame_err1),
        .overflow   (overflow1)
    );

    always @(negedge clk) begin
        if (parity_err0) perr0++;
        if (frame_err0)  ferr0++;
        if (overflow0)   ovf0++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_neg(4);
        ps2_clk = 1'b0;
        wait_neg(8);
        ps2_clk = 1'b1;
        wait_neg(4);
    endtask

    task automatic send_head(input logic [7:0] d, input bit even, input bit bad_par);
        logic p;
        p = even ? ^d : ~^d;
        if (bad_par) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit even, input bit bad_par);
        send_head(d, even, bad_par);
        send_bit(1'b1);
        wait_neg(6);
    endtask

    // Raises evt_ready for exactly the cycle in which dut0 pushes this frame's event.
    task automatic send_frame_pop(input logic [7:0] d);
        bit seen;
        seen = 1'b0;
        send_head(d, 1'b0, 1'b0);
        ps2_data = 1'b1;
        wait_neg(4);
        ps2_clk = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            wait_neg(1);
            if (dut0.u_fifo.push_i) begin
                seen = 1'b1;
                evt_ready = 1'b1;
                wait_neg(1);
                evt_ready = 1'b0;
            end
        end
        check_eq("push_seen", 32'(seen), 32'd1);
        wait_neg(4);
        ps2_clk = 1'b1;
        wait_neg(6);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        wait_neg(1);
        evt_ready = 1'b0;
    endtask

    task automatic check_head0(input string tag, input logic [7:0] c, input logic m,
                               input logic e);
        check_eq({tag, "_valid"}, 32'(evt_valid0), 32'd1);
        check_eq({tag, "_evt"}, 32'({evt_code0, evt_make0, evt_ext0}), 32'({c, m, e}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, f0, o0;
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt_ready = 1'b0;
        wait_neg(5);
        check_eq("rst_out0", 32'({evt_valid0, evt_code0, evt_make0, evt_ext0, evt_count0,
                                  parity_err0, frame_err0, overflow0}), 32'd0);
        check_eq("rst_out1", 32'({evt_valid1, evt_code1, evt_make1, evt_ext1, evt_count1,
                                  parity_err1, frame_err1, overflow1}), 32'd0);
        rst = 1'b0;
        wait_neg(5);

        // Single make code
        send_frame(8'h1C, 1'b0, 1'b0);
        check_head0("make_1c", 8'h1C, 1'b1, 1'b0);
        check_eq("make_1c_cnt", 32'(evt_count0), 32'd1);
        pop_one();
        check_eq("make_1c_popped", 32'(evt_valid0), 32'd0);
        check_eq("make_1c_cnt0", 32'(evt_count0), 32'd0);

        // Break codes with and without extension prefix
        send_frame(8'hF0, 1'b0, 1'b0);
        check_eq("prefix_no_evt", 32'(evt_count0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        check_eq("brk_cnt", 32'(evt_count0), 32'd2);
        check_head0("brk_1c", 8'h1C, 1'b0, 1'b0);
        pop_one();
        check_head0("brk_6b", 8'h6B, 1'b0, 1'b1);
        pop_one();
        check_eq("brk_empty", 32'(evt_count0), 32'd0);

        // Overflow with a 4-deep FIFO, then push accepted alongside a pop
        o0 = ovf0;
        send_frame(8'h15, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        check_eq("ovf_none_yet", 32'(ovf0 - o0), 32'd0);
        send_frame(8'h2C, 1'b0, 1'b0);
        check_eq("ovf_cnt", 32'(evt_count0), 32'd4);
        check_eq("ovf_pulse", 32'(ovf0 - o0), 32'd1);
        check_head0("ovf_head", 8'h15, 1'b1, 1'b0);
        send_frame_pop(8'h35);
        check_eq("ovf_pp_cnt", 32'(evt_count0), 32'd4);
        check_eq("ovf_pp_nodrop", 32'(ovf0 - o0), 32'd1);
        check_head0("ovf_d1", 8'h1D, 1'b1, 1'b0);
        pop_one();
        check_head0("ovf_d2", 8'h24, 1'b1, 1'b0);
        pop_one();
        check_head0("ovf_d3", 8'h2D, 1'b1, 1'b0);
        pop_one();
        check_head0("ovf_d4", 8'h35, 1'b1, 1'b0);
        pop_one();
        check_eq("ovf_drained", 32'(evt_count0), 32'd0);

        // Parity error discards the byte
        p0 = perr0;
        f0 = ferr0;
        send_frame(8'h29, 1'b0, 1'b1);
        check_eq("par_pulse", 32'(perr0 - p0), 32'd1);
        check_eq("par_no_ferr", 32'(ferr0 - f0), 32'd0);
        check_eq("par_no_evt", 32'(evt_count0), 32'd0);
        send_frame(8'h29, 1'b0, 1'b0);
        check_head0("par_next", 8'h29, 1'b1, 1'b0);
        pop_one();

        // Timeout after four data bits
        f0 = ferr0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_neg(150);
        check_eq("tmo_pulse", 32'(ferr0 - f0), 32'd1);
        check_eq("tmo_idle", 32'(dut0.state_q), 32'd0);
        check_eq("tmo_no_evt", 32'(evt_count0), 32'd0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_head0("tmo_next", 8'h75, 1'b1, 1'b1);
        pop_one();

        // Reset mid-frame with a non-empty FIFO
        send_frame(8'h1C, 1'b0, 1'b0);
        check_eq("mid_cnt", 32'(evt_count0), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        wait_neg(1);
        check_eq("mid_rst_out0", 32'({evt_valid0, evt_code0, evt_make0, evt_ext0, evt_count0,
                                      parity_err0, frame_err0, overflow0}), 32'd0);
        ps2_data = 1'b1;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(5);

        // Even parity instance decodes; odd parity instance rejects the same frame
        p0 = perr0;
        send_frame(8'h12, 1'b1, 1'b0);
        check_eq("even_valid", 32'(evt_valid1), 32'd1);
        check_eq("even_evt", 32'({evt_code1, evt_make1, evt_ext1}), 32'({8'h12, 1'b1, 1'b0}));
        check_eq("even_cnt", 32'(evt_count1), 32'd1);
        check_eq("even_odd_perr", 32'(perr0 - p0), 32'd1);
        check_eq("even_odd_none", 32'(evt_count0), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_head0("resume", 8'h1C, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_event_decoder.md
PS2_EVENT_DECODER -- requirements
Module: ps2_event_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, cycles the synchronised ps2_clk must hold a new level before it is accepted.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, ≥2), number of buffered key events.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 200000, idle cycles between ps2_clk falling edges that abort a frame in progress.
REQ-004 SHALL have parameter ODD_PARITY, default 1: 1 = odd parity, per the PS/2 standard; 0 = even parity, for benches that drive parity = ^data.
REQ-005 SHALL have ports: clk  in  1  system clock (single clock domain).
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ps2_clk  in  1  raw PS/2 clock, asynchronous.
REQ-008 ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-009 evt_valid  out  1  FIFO head holds an event.
REQ-010 evt_ready  in  1  consumer accepts the head event.
REQ-011 evt_code  out  8  head scan code.
REQ-012 evt_make  out  1  head event type: 1 = make (press), 0 = break (release).
REQ-013 evt_ext  out  1  head event was E0-prefixed.
REQ-014 evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 parity_err  out  1  one-cycle pulse on a parity failure.
REQ-016 frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-017 overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-018 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers, then filter ps2_clk with a FILTER_LEN stable-count filter; a bit is sampled on each falling edge of the filtered clock.
REQ-019 SHALL implement a frame FSM with states IDLE, DATA, PARITY, STOP.
- IDLE→DATA: sampled bit is 0 (start bit). A sampled 1 leaves the FSM in IDLE.
- DATA: collects 8 bits, LSB first.
- PARITY: receives the parity bit, then →STOP.
- STOP→IDLE always.
REQ-020 SHALL treat a byte as valid only if the stop bit is 1 and the parity check passes (ODD_PARITY: ^{data,parity}==1; else ==0).
- Parity failure: parity_err pulses and the byte is discarded.
- Stop bit 0: frame_err pulses and the byte is discarded.
REQ-021 SHALL, in any non-IDLE state, abort to IDLE and pulse frame_err when TIMEOUT_CYC cycles pass with no filtered falling edge.
REQ-022 SHALL decode valid bytes with ext and brk prefix flags:
- 0xE0 sets ext.
- 0xF0 sets brk.
- Any other byte pushes the event {code, make=~brk, ext} and clears both flags.
- Prefix bytes alone SHALL NOT create an event.
REQ-023 SHALL clear ext and brk on any discarded byte or timeout.
REQ-024 SHALL push the event 1 cycle after the stop-bit sample; evt_valid SHALL be high on the following cycle when the FIFO was empty (2-cycle latency).
REQ-025 SHALL pop the FIFO on evt_valid && evt_ready; evt_code, evt_make and evt_ext SHALL stay stable while evt_valid && !evt_ready.
REQ-026 SHALL handle a push while full: drop the event and pulse overflow, unless a pop occurs in the same cycle, in which case the push is accepted and evt_count stays FIFO_DEPTH.
REQ-027 SHALL handle a simultaneous push and pop when not full: evt_count unchanged. A pop while empty has no effect.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL on rst return the FSM to IDLE and clear the bit counter, shift register, ext, brk, timeout counter, filter state and FIFO pointers/count.
- Outputs: evt_valid=0, evt_code=0, evt_make=0, evt_ext=0, evt_count=0, all error pulses 0.
REQ-030 SHALL discard any partial frame when rst is asserted mid-frame; reception resumes at the next start bit after rst deasserts.

Structure
REQ-031 SHALL take the event struct type (code, make, ext) and the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0 from the shared package ps2_pkg.
REQ-032 SHALL instantiate a sub-module ps2_event_fifo (synchronous FIFO, parameterised depth and struct payload); the frame FSM and the decoder stay in the top module.

Verification
REQ-033 Odd parity: send 0x1C -> one event {1C, make=1, ext=0}, evt_count=1; evt_ready=1 -> evt_valid=0.
REQ-034 Send F0 1C, then E0 F0 6B, with evt_ready=0 -> two events {1C,0,0} and {6B,0,1} in order; no event from the prefixes.
REQ-035 FIFO_DEPTH=4, evt_ready=0, send 5 make codes -> evt_count=4, one overflow pulse, the first 4 codes are retained; a 6th push in the same cycle as a pop -> accepted.
REQ-036 Wrong parity bit on 0x29 -> parity_err pulse, no event; a following 0x29 is decoded normally with make=1.
REQ-037 Stop after 4 data bits for >TIMEOUT_CYC cycles -> frame_err pulse, FSM returns to IDLE; next byte E0 75 -> {75,1,1}.
REQ-038 Assert rst mid-frame and with the FIFO non-empty -> all outputs 0; ODD_PARITY=0 with bench parity ^data -> 0x12 decoded as {12,1,0}.
